// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Package     : vga_pkg
// Description : Shared VGA timing presets, width helpers and pixel field slices.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

    typedef struct packed {
        int unsigned active;
        int unsigned fp;
        int unsigned sync;
        int unsigned bp;
    } vga_axis_t;

    // Raw control bits travelling with a pixel; hs/vs mean "sync asserted".
    typedef struct packed {
        logic hs;
        logic vs;
        logic act;
    } vga_ctl_t;

    localparam vga_axis_t c_h_640x480 = '{active: 640, fp: 16, sync: 96,  bp: 48};
    localparam vga_axis_t c_v_640x480 = '{active: 480, fp: 10, sync: 2,   bp: 33};
    localparam vga_axis_t c_h_800x600 = '{active: 800, fp: 40, sync: 128, bp: 88};
    localparam vga_axis_t c_v_800x600 = '{active: 600, fp: 1,  sync: 4,   bp: 23};

    function automatic int unsigned h_total(input int unsigned a, input int unsigned fp,
                                            input int unsigned s, input int unsigned bp);
        return a + fp + s + bp;
    endfunction

    function automatic int unsigned v_total(input int unsigned a, input int unsigned fp,
                                            input int unsigned s, input int unsigned bp);
        return a + fp + s + bp;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned total);
        return (total > 1) ? $clog2(total) : 1;
    endfunction

    function automatic logic [7:0] rgb_r(input logic [23:0] px);
        return px[23:16];
    endfunction

    function automatic logic [7:0] rgb_g(input logic [23:0] px);
        return px[15:8];
    endfunction

    function automatic logic [7:0] rgb_b(input logic [23:0] px);
        return px[7:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : Pixel-tick divider, H/V counters and raw sync/active decode.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CLK_DIV  = 1,
    parameter int HW       = 10,
    parameter int VW       = 10
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          en_i,
    output logic          tick_o,
    output logic [HW-1:0] h_cnt_o,
    output logic [VW-1:0] v_cnt_o,
    output vga_ctl_t      ctl_o
);

    localparam int unsigned c_h_total = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned c_v_total = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int          c_dw      = cnt_width(CLK_DIV);

    localparam logic [c_dw-1:0] c_div_last = c_dw'(CLK_DIV - 1);
    localparam logic [HW-1:0]   c_h_last   = HW'(c_h_total - 1);
    localparam logic [VW-1:0]   c_v_last   = VW'(c_v_total - 1);
    localparam logic [HW-1:0]   c_h_act    = HW'(H_ACTIVE);
    localparam logic [VW-1:0]   c_v_act    = VW'(V_ACTIVE);
    localparam logic [HW-1:0]   c_hs_beg   = HW'(H_ACTIVE + H_FP);
    localparam logic [VW-1:0]   c_vs_beg   = VW'(V_ACTIVE + V_FP);
    localparam logic [HW-1:0]   c_hs_len   = HW'(H_SYNC);
    localparam logic [VW-1:0]   c_vs_len   = VW'(V_SYNC);

    logic [c_dw-1:0] div_q, div_d;
    logic [HW-1:0]   h_q, h_d;
    logic [VW-1:0]   v_q, v_d;
    logic            w_tick;
    logic [HW-1:0]   w_h_off;
    logic [VW-1:0]   w_v_off;

    assign w_tick = en_i && (div_q == c_div_last);

    always_comb begin
        div_d = div_q;
        h_d   = h_q;
        v_d   = v_q;
        if (en_i) begin
            div_d = w_tick ? '0 : div_q + 1'b1;
        end
        if (w_tick) begin
            if (h_q == c_h_last) begin
                h_d = '0;
                v_d = (v_q == c_v_last) ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_q <= '0;
            h_q   <= '0;
            v_q   <= '0;
        end else begin
            div_q <= div_d;
            h_q   <= h_d;
            v_q   <= v_d;
        end
    end

    // Modular offset makes the sync window test immune to end == 2**width.
    assign w_h_off   = h_q - c_hs_beg;
    assign w_v_off   = v_q - c_vs_beg;
    assign ctl_o.hs  = (w_h_off < c_hs_len);
    assign ctl_o.vs  = (w_v_off < c_vs_len);
    assign ctl_o.act = (h_q < c_h_act) && (v_q < c_v_act);

    assign tick_o  = w_tick;
    assign h_cnt_o = h_q;
    assign v_cnt_o = v_q;

endmodule
`default_nettype wire

// File: rtl/vga_ctrl_param.sv
`default_nettype none
// ============================================================================
// Module      : vga_ctrl_param
// Description : Parametrised VGA controller: address stage, latency-matching
//               delay pipe for sync/blank and registered colour output.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_ctrl_param
    import vga_pkg::*;
#(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter bit SYNC_POL   = 1'b0,
    parameter int CLK_DIV    = 1,
    parameter int SCALE_LOG2 = 0,
    parameter int RD_LATENCY = 1,
    parameter int AW_H       = 10,
    parameter int AW_V       = 10
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            en_i,
    output logic [AW_H-1:0] h_addr_o,
    output logic [AW_V-1:0] v_addr_o,
    output logic            fb_rd_en_o,
    input  logic [23:0]     vga_data_i,
    output logic            hsync_o,
    output logic            vsync_o,
    output logic            valid_o,
    output logic [7:0]      vga_r_o,
    output logic [7:0]      vga_g_o,
    output logic [7:0]      vga_b_o,
    output logic            frame_start_o
);

    localparam int c_hw = cnt_width(h_total(H_ACTIVE, H_FP, H_SYNC, H_BP));
    localparam int c_vw = cnt_width(v_total(V_ACTIVE, V_FP, V_SYNC, V_BP));

    if ((H_ACTIVE >> SCALE_LOG2) > (1 << AW_H) || (V_ACTIVE >> SCALE_LOG2) > (1 << AW_V)) begin : g_chk_aw
        $error("vga_ctrl_param: scaled active area does not fit AW_H/AW_V");
    end
    if (CLK_DIV < 1 || SCALE_LOG2 < 0 || SCALE_LOG2 > 3 || RD_LATENCY < 0 || RD_LATENCY > 4) begin : g_chk_rng
        $error("vga_ctrl_param: CLK_DIV, SCALE_LOG2 or RD_LATENCY out of range");
    end

    logic             w_tick;
    logic [c_hw-1:0]  w_h_cnt;
    logic [c_vw-1:0]  w_v_cnt;
    vga_ctl_t         w_ctl;
    vga_ctl_t         w_tail;

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
        .CLK_DIV  (CLK_DIV),  .HW   (c_hw), .VW     (c_vw)
    ) u_timing (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .en_i    (en_i),
        .tick_o  (w_tick),
        .h_cnt_o (w_h_cnt),
        .v_cnt_o (w_v_cnt),
        .ctl_o   (w_ctl)
    );

    logic [AW_H-1:0] h_addr_q, h_addr_d;
    logic [AW_V-1:0] v_addr_q, v_addr_d;
    logic            fb_rd_en_q;
    vga_ctl_t        ctl0_q;
    logic            frame_start_q;
    logic            hsync_q, vsync_q, valid_q;
    logic [23:0]     rgb_q;

    always_comb begin
        h_addr_d = '0;
        v_addr_d = '0;
        if (w_ctl.act) begin
            h_addr_d = AW_H'(w_h_cnt >> SCALE_LOG2);
            v_addr_d = AW_V'(w_v_cnt >> SCALE_LOG2);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            h_addr_q   <= '0;
            v_addr_q   <= '0;
            fb_rd_en_q <= 1'b0;
            ctl0_q     <= '0;
        end else if (w_tick) begin
            h_addr_q   <= h_addr_d;
            v_addr_q   <= v_addr_d;
            fb_rd_en_q <= w_ctl.act;
            ctl0_q     <= w_ctl;
        end
    end

    // Clocked every cycle (not on tick) so the pulse stays one clock wide.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            frame_start_q <= 1'b0;
        end else begin
            frame_start_q <= w_tick && (w_h_cnt == '0) && (w_v_cnt == '0);
        end
    end

    if (RD_LATENCY == 0) begin : g_direct
        assign w_tail = ctl0_q;
    end else begin : g_pipe
        vga_ctl_t pipe_q [RD_LATENCY];

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                for (int k = 0; k < RD_LATENCY; k++) begin
                    pipe_q[k] <= '0;
                end
            end else if (w_tick) begin
                pipe_q[0] <= ctl0_q;
                for (int k = 1; k < RD_LATENCY; k++) begin
                    pipe_q[k] <= pipe_q[k-1];
                end
            end
        end

        assign w_tail = pipe_q[RD_LATENCY-1];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hsync_q <= ~SYNC_POL;
            vsync_q <= ~SYNC_POL;
            valid_q <= 1'b0;
            rgb_q   <= '0;
        end else if (w_tick) begin
            hsync_q <= w_tail.hs ? SYNC_POL : ~SYNC_POL;
            vsync_q <= w_tail.vs ? SYNC_POL : ~SYNC_POL;
            valid_q <= w_tail.act;
            rgb_q   <= w_tail.act ? vga_data_i : 24'd0;
        end
    end

    assign h_addr_o      = h_addr_q;
    assign v_addr_o      = v_addr_q;
    assign fb_rd_en_o    = fb_rd_en_q;
    assign hsync_o       = hsync_q;
    assign vsync_o       = vsync_q;
    assign valid_o       = valid_q;
    assign vga_r_o       = rgb_r(rgb_q);
    assign vga_g_o       = rgb_g(rgb_q);
    assign vga_b_o       = rgb_b(rgb_q);
    assign frame_start_o = frame_start_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_ctrl_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_ctrl_param
// Description : Randomised en/reset stimulus on two parameter sets, compared
//               against a tick-count based reference of the VGA raster.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_ctrl_param;

    logic clk;
    logic rst;
    logic en;
    int   n_checks = 0;
    int   n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=0x%0h expected=0x%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [23:0] pix_hash(input int x, input int y);
        logic [7:0] r, g, b;
        r = 8'(x * 29 + y * 3 + 7);
        g = 8'(y * 53 + 11);
        b = 8'(x ^ (y << 4));
        return {r, g, b};
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : g_cfg
        localparam int HA   = (gi == 0) ? 16 : 12;
        localparam int HF   = (gi == 0) ? 2  : 1;
        localparam int HS   = (gi == 0) ? 3  : 2;
        localparam int HB   = (gi == 0) ? 3  : 1;
        localparam int VA   = (gi == 0) ? 8  : 6;
        localparam int VF   = 1;
        localparam int VS   = (gi == 0) ? 2  : 1;
        localparam int VB   = 2;
        localparam bit POL  = (gi == 0) ? 1'b0 : 1'b1;
        localparam int DIV  = (gi == 0) ? 3  : 1;
        localparam int S    = (gi == 0) ? 1  : 0;
        localparam int L    = (gi == 0) ? 2  : 0;
        localparam int AWH  = (gi == 0) ? 3  : 4;
        localparam int AWV  = (gi == 0) ? 2  : 3;
        localparam int HT   = HA + HF + HS + HB;
        localparam int VT   = VA + VF + VS + VB;
        localparam int FRM  = HT * VT;

        logic [AWH-1:0] h_addr;
        logic [AWV-1:0] v_addr;
        logic           fb_rd_en, hsync, vsync, valid, frame_start;
        logic [7:0]     vr, vg, vb;
        logic [23:0]    vga_data;
        logic [23:0]    vm [4];
        int             ticks = 0;
        int             en_cnt = 0;
        bit             last_tick = 1'b0;
        bit             started = 1'b0;

        vga_ctrl_param #(
            .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
            .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
            .SYNC_POL (POL), .CLK_DIV (DIV), .SCALE_LOG2 (S),
            .RD_LATENCY (L), .AW_H (AWH), .AW_V (AWV)
        ) u_dut (
            .clk_i         (clk),
            .rst_i         (rst),
            .en_i          (en),
            .h_addr_o      (h_addr),
            .v_addr_o      (v_addr),
            .fb_rd_en_o    (fb_rd_en),
            .vga_data_i    (vga_data),
            .hsync_o       (hsync),
            .vsync_o       (vsync),
            .valid_o       (valid),
            .vga_r_o       (vr),
            .vga_g_o       (vg),
            .vga_b_o       (vb),
            .frame_start_o (frame_start)
        );

        // Framebuffer: data for an address appears L pixel ticks later.
        if (L == 0) begin : g_vm_comb
            assign vga_data = pix_hash(int'(h_addr), int'(v_addr));
        end else begin : g_vm_reg
            assign vga_data = vm[L-1];
        end

        // Reference tick bookkeeping: a tick is every DIV-th enabled clock.
        always @(posedge clk) begin
            started = 1'b1;
            if (rst) begin
                ticks     = 0;
                en_cnt    = 0;
                last_tick = 1'b0;
                for (int k = 0; k < 4; k++) vm[k] <= 24'd0;
            end else begin
                last_tick = 1'b0;
                if (en) begin
                    en_cnt++;
                    if (en_cnt % DIV == 0) begin
                        last_tick = 1'b1;
                        ticks++;
                        vm[0] <= pix_hash(int'(h_addr), int'(v_addr));
                        for (int k = 1; k < 4; k++) vm[k] <= vm[k-1];
                    end
                end
            end
        end

        // After t ticks the address stage shows pixel t-1, the pins pixel t-L-2.
        always @(negedge clk) begin
            int  q, h, v, ex_h, ex_v;
            bit  act, ex_fb, ex_hs, ex_vs, ex_valid, ex_fs;
            logic [23:0] ex_rgb;
            if (started) begin
                ex_fb = 1'b0; ex_h = 0; ex_v = 0;
                if (ticks >= 1) begin
                    q = (ticks - 1) % FRM; h = q % HT; v = q / HT;
                    act = (h < HA) && (v < VA);
                    ex_fb = act;
                    ex_h  = act ? ((h >> S) % (1 << AWH)) : 0;
                    ex_v  = act ? ((v >> S) % (1 << AWV)) : 0;
                end
                ex_hs = ~POL; ex_vs = ~POL; ex_valid = 1'b0; ex_rgb = 24'd0;
                if (ticks >= L + 2) begin
                    q = (ticks - L - 2) % FRM; h = q % HT; v = q / HT;
                    act      = (h < HA) && (v < VA);
                    ex_valid = act;
                    ex_hs    = (h >= HA + HF && h < HA + HF + HS) ? POL : ~POL;
                    ex_vs    = (v >= VA + VF && v < VA + VF + VS) ? POL : ~POL;
                    ex_rgb   = act ? pix_hash((h >> S) % (1 << AWH), (v >> S) % (1 << AWV)) : 24'd0;
                end
                ex_fs = last_tick && (ticks >= 1) && (((ticks - 1) % FRM) == 0);
                check_eq($sformatf("c%0d.h_addr", gi), 32'(h_addr), 32'(ex_h));
                check_eq($sformatf("c%0d.v_addr", gi), 32'(v_addr), 32'(ex_v));
                check_eq($sformatf("c%0d.fb_rd_en", gi), 32'(fb_rd_en), 32'(ex_fb));
                check_eq($sformatf("c%0d.hsync", gi), 32'(hsync), 32'(ex_hs));
                check_eq($sformatf("c%0d.vsync", gi), 32'(vsync), 32'(ex_vs));
                check_eq($sformatf("c%0d.valid", gi), 32'(valid), 32'(ex_valid));
                check_eq($sformatf("c%0d.rgb", gi), 32'({vr, vg, vb}), 32'(ex_rgb));
                check_eq($sformatf("c%0d.frame_start", gi), 32'(frame_start), 32'(ex_fs));
            end
        end
    end

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        en  = 1'b1;
        repeat (1200) @(negedge clk);
        en = 1'b0;
        repeat (37) @(negedge clk);
        en = 1'b1;
        repeat (1013) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int cyc = 0; cyc < 4500; cyc++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 1499) == 0);
            if ($urandom_range(0, 63) == 0) begin
                en = 1'b0;
                repeat ($urandom_range(5, 40)) @(negedge clk);
            end
            en = ($urandom_range(0, 4) != 0);
        end
        rst = 1'b0;
        en  = 1'b1;
        repeat (20) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
